// File: rtl/load_store_unit.sv
// Load/store unit: turns one memory op into a single word-aligned bus access.
// It handles lane steering, load extension, alignment faults and bus timeouts.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        start,
  input  logic [5:0]  memOP,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic [31:0] busRdata,
  input  logic        busAck,
  output logic        busRead,
  output logic        busWrite,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busByteEn,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic        misaligned,
  output logic        timeout
);

  localparam logic [5:0] CU_LB  = 6'd10;
  localparam logic [5:0] CU_LH  = 6'd11;
  localparam logic [5:0] CU_LW  = 6'd12;
  localparam logic [5:0] CU_LBU = 6'd13;
  localparam logic [5:0] CU_LHU = 6'd14;
  localparam logic [5:0] CU_SB  = 6'd15;
  localparam logic [5:0] CU_SH  = 6'd16;
  localparam logic [5:0] CU_SW  = 6'd17;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  cnt_r;
  logic [5:0]  op_r;
  logic [1:0]  lane_r;

  function automatic logic op_valid(input logic [5:0] op);
    return (op >= CU_LB) && (op <= CU_SW);
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    return op <= CU_LHU;
  endfunction

  // Access size code: 0 = byte, 1 = halfword, 2 = word.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      CU_LB, CU_LBU, CU_SB: op_size = 2'd0;
      CU_LH, CU_LHU, CU_SH: op_size = 2'd1;
      CU_LW, CU_SW:         op_size = 2'd2;
      default:              op_size = 2'd2;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op_size(op))
      2'd1:    op_misaligned = lo[0];
      2'd2:    op_misaligned = |lo;
      default: op_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [5:0] op, input logic [1:0] lo);
    case (op_size(op))
      2'd0:    lane_enables = 4'b0001 << lo;
      2'd1:    lane_enables = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] write_lanes(input logic [5:0] op, input logic [31:0] d);
    case (op_size(op))
      2'd0:    write_lanes = {4{d[7:0]}};
      2'd1:    write_lanes = {2{d[15:0]}};
      default: write_lanes = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lo,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lo, 3'b000};
    case (op)
      CU_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
      CU_LBU:  load_extend = {24'd0, sh[7:0]};
      CU_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
      CU_LHU:  load_extend = {16'd0, sh[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  // Next-state logic; an ack in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && op_valid(memOP)) begin
          if (op_misaligned(memOP, addr[1:0])) begin
            state_s = FAULT;
          end else begin
            state_s = ACCESS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (busAck) begin
          state_s = DONE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_s = FAULT;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE:    state_s = IDLE;
      FAULT:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, capture registers and all registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      op_r       <= 6'd0;
      lane_r     <= 2'd0;
      busRead    <= 1'b0;
      busWrite   <= 1'b0;
      busAddr    <= 32'd0;
      busWdata   <= 32'd0;
      busByteEn  <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      loadData   <= 32'd0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy       <= (state_s != IDLE);
      done       <= (state_s == DONE) || (state_s == FAULT);
      misaligned <= (state_r == IDLE) && (state_s == FAULT);
      timeout    <= (state_r == ACCESS) && (state_s == FAULT);
      if ((state_r == IDLE) && (state_s == ACCESS)) begin
        op_r      <= memOP;
        lane_r    <= addr[1:0];
        cnt_r     <= 8'd0;
        busAddr   <= {addr[31:2], 2'b00};
        busByteEn <= lane_enables(memOP, addr[1:0]);
        busWdata  <= write_lanes(memOP, storeData);
        busRead   <= op_is_load(memOP);
        busWrite  <= !op_is_load(memOP);
      end else if (state_s == ACCESS) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        busRead  <= 1'b0;
        busWrite <= 1'b0;
      end
      if ((state_r == ACCESS) && (state_s == DONE) && op_is_load(op_r)) begin
        loadData <= load_extend(op_r, lane_r, busRdata);
      end else begin
        loadData <= loadData;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit, checked against an arithmetic model of each transaction.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        nRst;
  logic        start;
  logic [5:0]  memOP;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic [31:0] busRdata;
  logic        busAck;
  logic        busRead;
  logic        busWrite;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busByteEn;
  logic        busy;
  logic        done;
  logic [31:0] loadData;
  logic        misaligned;
  logic        timeout;

  int          tests_run = 0;
  int          fails = 0;
  logic [31:0] model_load;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .nRst(nRst), .start(start), .memOP(memOP), .addr(addr),
    .storeData(storeData), .busRdata(busRdata), .busAck(busAck),
    .busRead(busRead), .busWrite(busWrite), .busAddr(busAddr), .busWdata(busWdata),
    .busByteEn(busByteEn), .busy(busy), .done(done), .loadData(loadData),
    .misaligned(misaligned), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int op_bytes(input logic [5:0] op);
    if (op == 6'd10 || op == 6'd13 || op == 6'd15) return 1;
    if (op == 6'd11 || op == 6'd14 || op == 6'd16) return 2;
    return 4;
  endfunction

  // Drives one legal op from a negedge with the DUT idle; ends at a negedge with the DUT idle.
  // ack_k: ACCESS cycle (1-based) in which busAck is raised; outside 1..T means never.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int ack_k, input bit noise);
    int          s;
    int          n;
    bit          ld;
    bit          mis;
    bit          to;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [31:0] v;
    logic [3:0]  exp_be;
    s        = op_bytes(op);
    ld       = (op <= 6'd14);
    mis      = (a % s) != 0;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_be   = 4'(((1 << s) - 1) << (a % 4));
    if (s == 1)      exp_wd = (sd & 32'hFF) * 32'h0101_0101;
    else if (s == 2) exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
    else             exp_wd = sd;
    v = rd >> (8 * (a % 4));
    if (s == 1) begin
      v = v & 32'hFF;
      if (op == 6'd10 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (s == 2) begin
      v = v & 32'hFFFF;
      if (op == 6'd11 && v[15]) v = v | 32'hFFFF_0000;
    end
    to = !(ack_k >= 1 && ack_k <= T);
    n  = to ? T : ack_k;

    memOP = op; addr = a; storeData = sd; busRdata = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mis) begin
      tests_run++;
      if ({done, misaligned, timeout, busRead, busWrite, busy} !== 6'b110001 || loadData !== model_load) begin
        fails++;
        $display("FAIL misaligned op=%0d addr=%h: flags(d,m,t,r,w,b)=%b load=%h, need 110001 load=%h",
                 op, a, {done, misaligned, timeout, busRead, busWrite, busy}, loadData, model_load);
      end
    end else begin
      for (int c = 1; c <= n; c++) begin
        tests_run++;
        if ({busRead, busWrite, busy, done, misaligned, timeout} !== {ld, !ld, 1'b1, 1'b0, 1'b0, 1'b0} ||
            busAddr !== exp_addr || busByteEn !== exp_be || (!ld && busWdata !== exp_wd)) begin
          fails++;
          $display("FAIL access op=%0d addr=%h cyc=%0d: r=%b w=%b busy=%b done=%b ba=%h be=%b wd=%h, need r=%b w=%b ba=%h be=%b wd=%h",
                   op, a, c, busRead, busWrite, busy, done, busAddr, busByteEn, busWdata,
                   ld, !ld, exp_addr, exp_be, exp_wd);
        end
        busAck = (c == ack_k);
        start  = noise;
        @(negedge clk);
      end
      busAck = 1'b0;
      start  = 1'b0;
      if (!to && ld) model_load = v;
      tests_run++;
      if ({done, misaligned, timeout, busRead, busWrite} !== {1'b1, 1'b0, to, 1'b0, 1'b0} ||
          loadData !== model_load) begin
        fails++;
        $display("FAIL finish op=%0d addr=%h ack=%0d: d,m,t,r,w=%b load=%h, need %b load=%h",
                 op, a, ack_k, {done, misaligned, timeout, busRead, busWrite}, loadData,
                 {1'b1, 1'b0, to, 1'b0, 1'b0}, model_load);
      end
    end
    @(negedge clk);
    tests_run++;
    if ({done, misaligned, timeout, busy, busRead, busWrite} !== 6'b000000) begin
      fails++;
      $display("FAIL return_idle op=%0d addr=%h: d,m,t,busy,r,w=%b, need 000000",
               op, a, {done, misaligned, timeout, busy, busRead, busWrite});
    end
  endtask

  task automatic test_reset;
    nRst = 1'b0; start = 1'b0; memOP = 6'd0; addr = 32'd0; storeData = 32'd0;
    busRdata = 32'd0; busAck = 1'b0; model_load = 32'd0;
    #1;
    tests_run++;
    if ({busRead, busWrite, busy, done, misaligned, timeout} !== 6'b0 || busAddr !== 32'd0 ||
        busWdata !== 32'd0 || loadData !== 32'd0 || busByteEn !== 4'd0) begin
      fails++;
      $display("FAIL reset: flags=%b ba=%h wd=%h ld=%h be=%b, need all zero",
               {busRead, busWrite, busy, done, misaligned, timeout}, busAddr, busWdata, loadData, busByteEn);
    end
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_op(6'd10, 32'h0000_1003, 32'd0, 32'h80FF_1234, 2, 1'b0);
    tests_run++;
    if (loadData !== 32'hFFFF_FF80) begin
      fails++; $display("FAIL lb_sext: loadData=%h, need ffffff80", loadData);
    end
    run_op(6'd13, 32'h0000_1003, 32'd0, 32'h80FF_1234, 2, 1'b0);
    tests_run++;
    if (loadData !== 32'h0000_0080) begin
      fails++; $display("FAIL lbu_zext: loadData=%h, need 00000080", loadData);
    end
    run_op(6'd11, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 1, 1'b0);
    tests_run++;
    if (loadData !== 32'hFFFF_BEEF) begin
      fails++; $display("FAIL lh_sext: loadData=%h, need ffffbeef", loadData);
    end
    run_op(6'd14, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 1, 1'b0);
    tests_run++;
    if (loadData !== 32'h0000_BEEF) begin
      fails++; $display("FAIL lhu_zext: loadData=%h, need 0000beef", loadData);
    end
    run_op(6'd15, 32'h0000_3001, 32'h0000_00AB, 32'hFFFF_FFFF, 1, 1'b0);
    tests_run++;
    if (loadData !== 32'h0000_BEEF) begin
      fails++; $display("FAIL sb_keeps_load: loadData=%h, need 0000beef", loadData);
    end
    run_op(6'd12, 32'h0000_4002, 32'd0, 32'd0, 1, 1'b0);
  endtask

  task automatic test_timeout;
    run_op(6'd17, 32'h0000_5000, 32'hCAFE_F00D, 32'd0, 0, 1'b0);
    run_op(6'd17, 32'h0000_5004, 32'h1234_5678, 32'd0, T, 1'b0);
  endtask

  task automatic test_ignored;
    busAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int x;
      x = $urandom_range(0, 55);
      if (x >= 10) x = x + 8;
      memOP = 6'(x); addr = $urandom; start = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({busy, done, busRead, busWrite} !== 4'b0000) begin
        fails++;
        $display("FAIL ignore op=%0d: busy,done,r,w=%b, need 0000", x, {busy, done, busRead, busWrite});
      end
    end
    busAck = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [5:0]  op;
      logic [31:0] a;
      op = 6'(10 + $urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(op_bytes(op) - 1);
      run_op(op, a, $urandom, $urandom, $urandom_range(1, 5), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_async_reset;
    memOP = 6'd10; addr = 32'h0000_6000; busRdata = 32'h0000_0055; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busRead !== 1'b1) begin
      fails++; $display("FAIL pre_reset_access: busRead=%b, need 1", busRead);
    end
    nRst = 1'b0;
    #1;
    model_load = 32'd0;
    tests_run++;
    if ({busRead, busWrite, busy, done} !== 4'b0000 || busAddr !== 32'd0 ||
        loadData !== 32'd0 || busByteEn !== 4'd0 || busWdata !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: r,w,busy,done=%b ba=%h ld=%h be=%b, need zeros",
               {busRead, busWrite, busy, done}, busAddr, loadData, busByteEn);
    end
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    run_op(6'd12, 32'h0000_0000, 32'd0, 32'h1234_5678, 1, 1'b0);
    tests_run++;
    if (loadData !== 32'h1234_5678) begin
      fails++; $display("FAIL lw_after_reset: loadData=%h, need 12345678", loadData);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ignored();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max ACCESS cycles awaiting busAck before fault (legal 1..255).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port nRst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  in  1  request valid; sampled only in IDLE.
REQ-005 SHALL have port memOP  in  6  cuOPType code: CU_LB=10, CU_LH=11, CU_LW=12, CU_LBU=13, CU_LHU=14, CU_SB=15, CU_SH=16, CU_SW=17.
REQ-006 SHALL have port addr  in  32  effective address (ALU ALUResult).
REQ-007 SHALL have port storeData  in  32  rs2 value for stores.
REQ-008 SHALL have port busRdata  in  32  bus read word.
REQ-009 SHALL have port busAck  in  1  bus completion, one cycle.
REQ-010 SHALL have port busRead  out  1  read strobe.
REQ-011 SHALL have port busWrite  out  1  write strobe.
REQ-012 SHALL have port busAddr  out  32  word-aligned address.
REQ-013 SHALL have port busWdata  out  32  lane-replicated write data.
REQ-014 SHALL have port busByteEn  out  4  byte lanes, bit i = byte i (little-endian).
REQ-015 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port loadData  out  32  extended load result.
REQ-018 SHALL have port misaligned  out  1  alignment fault, valid with done.
REQ-019 SHALL have port timeout  out  1  bus timeout fault, valid with done.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, DONE, FAULT; all outputs registered.
REQ-021 IDLE: start=1 with memOP in 10..17 and aligned addr SHALL capture op/addr/data and go ACCESS next cycle; start with any other memOP SHALL be ignored.
REQ-022 Alignment: halfword ops with addr[0]=1, word ops with addr[1:0]!=0 SHALL go FAULT with no bus strobe ever asserted.
REQ-023 ACCESS: busRead (loads) or busWrite (stores) SHALL be held high, busAddr={addr[31:2],2'b00}, until busAck sampled high -> DONE.
REQ-024 Byte enables: byte ops 1<<addr[1:0]; halfword addr[1]=0 -> 0011, addr[1]=1 -> 1100; word 1111; same for loads and stores.
REQ-025 busWdata: SB = byte replicated x4; SH = halfword replicated x2; SW = storeData.
REQ-026 Loads SHALL select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough; loadData updated on the ACCESS->DONE edge, held otherwise (stores and faults leave it unchanged).
REQ-027 DONE: done=1 one cycle, strobes low, then IDLE; minimum start-to-done latency 2 cycles (start edge, ack in first ACCESS cycle).
REQ-028 Timeout counter SHALL clear on ACCESS entry, increment each ACCESS cycle; after TIMEOUT_CYCLES cycles without ack -> FAULT.
REQ-029 busAck and timeout expiry in the same cycle: ack SHALL win (DONE, timeout=0).
REQ-030 FAULT: done=1 and exactly one of misaligned/timeout =1 for one cycle, strobes low, then IDLE.
REQ-031 misaligned and timeout SHALL be 0 in every cycle where done=0.
REQ-032 start while busy SHALL be ignored (no queuing); busAck outside ACCESS SHALL be ignored.

Reset
REQ-033 nRst low SHALL immediately (asynchronously) force IDLE, counter 0, busRead=busWrite=busy=done=misaligned=timeout=0, busAddr=busWdata=loadData=0, busByteEn=0000.
REQ-034 Reset mid-ACCESS SHALL abort the transaction; first start after nRst release SHALL be accepted normally.

Verification
REQ-035 LB addr=0x1003, busRdata=0x80FF1234, ack on 2nd ACCESS cycle -> busAddr=0x1000, busByteEn=1000, loadData=0xFFFFFF80, done one cycle; LBU same -> 0x00000080.
REQ-036 LH/LHU addr=0x2002, busRdata=0xBEEF0000 -> busByteEn=1100, loadData 0xFFFFBEEF / 0x0000BEEF.
REQ-037 SB addr=0x3001, storeData=0x000000AB -> busWrite=1, busByteEn=0010, busWdata=0xABABABAB, loadData unchanged.
REQ-038 LW addr=0x4002 -> busRead never high, done=1 and misaligned=1 on cycle after start.
REQ-039 TIMEOUT_CYCLES=4, SW, no ack -> busWrite high exactly 4 cycles, then done=1, timeout=1; repeat with ack on 4th cycle -> done, timeout=0.
REQ-040 nRst pulsed low during ACCESS -> busRead drops without clock edge; subsequent LW addr=0x0 accepted and completes.
